// File: rtl/md_sched.sv
// Multiply/divide scheduler: fixed-latency mult/div with HI/LO ownership and D-stage stall.
// Define MD_SCHED_MADD_EN to enable the madd/maddu/msub/msubu accumulate ops (md_op 1xx).
module md_sched #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        d_is_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned CW = 4;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [63:0]     pend_q, pend_d;
  logic            skip_q, skip_d;

  logic            is_div, op_ok, accept;
  logic [63:0]     a_sx, b_sx, a_zx, b_zx, prod_s, prod_u, result;
  logic            sgn;
  logic [31:0]     abs_a, abs_b, dvsr, q_mag, r_mag, div_q, div_r;

  assign is_div = (md_op[2:1] == 2'b01);
`ifdef MD_SCHED_MADD_EN
  assign op_ok  = 1'b1;
`else
  assign op_ok  = ~md_op[2];
`endif
  assign accept = start & op_ok & (state_q == IDLE);

  // 64-bit products from explicitly extended operands
  assign a_sx   = {{32{src_a[31]}}, src_a};
  assign b_sx   = {{32{src_b[31]}}, src_b};
  assign a_zx   = {32'd0, src_a};
  assign b_zx   = {32'd0, src_b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // One unsigned divider on magnitudes; signs are restored afterwards, which also
  // yields 0x80000000 / -1 = 0x80000000 rem 0 without special-casing.
  assign sgn   = ~md_op[0];
  assign abs_a = (sgn && src_a[31]) ? (~src_a + 32'd1) : src_a;
  assign abs_b = (sgn && src_b[31]) ? (~src_b + 32'd1) : src_b;
  assign dvsr  = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign q_mag = abs_a / dvsr;
  assign r_mag = abs_a % dvsr;
  assign div_q = (sgn && (src_a[31] ^ src_b[31])) ? (~q_mag + 32'd1) : q_mag;
  assign div_r = (sgn && src_a[31]) ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    result = prod_s;
    case (md_op)
      3'b000:         result = prod_s;
      3'b001:         result = prod_u;
      3'b010, 3'b011: result = {div_r, div_q};
`ifdef MD_SCHED_MADD_EN
      3'b100:         result = {hi_q, lo_q} + prod_s;
      3'b101:         result = {hi_q, lo_q} + prod_u;
      3'b110:         result = {hi_q, lo_q} - prod_s;
      3'b111:         result = {hi_q, lo_q} - prod_u;
`endif
      default:        result = prod_s;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    pend_d  = pend_q;
    skip_d  = skip_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          pend_d  = result;
          skip_d  = is_div && (src_b == 32'd0);
        end else if (!start) begin
          if (hi_we) hi_d = src_a;
          if (lo_we) lo_d = src_a;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = IDLE;
          if (!skip_q) begin
            hi_d = pend_q[63:32];
            lo_d = pend_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      pend_q  <= '0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      pend_q  <= pend_d;
      skip_q  <= skip_d;
    end
  end

  assign busy     = (state_q == RUN);
  assign md_stall = d_is_md & (accept | busy);
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule
